bw_block_downscale: RTL and testbench



---
 rtl/bw_block_downscale_pkg.sv | 26 ++
 rtl/bw_block_downscale_col_acc_ram.sv | 27 ++
 rtl/bw_block_downscale.sv | 177 +++++++++++++++++
 tb/tb_bw_block_downscale.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/bw_block_downscale_pkg.sv
// Shared constants for the block downscaler and its downstream frame RAM / detector.
package bw_block_downscale_pkg;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int BLK_LOG2 = 3;

    localparam int BLK      = 1 << BLK_LOG2;
    localparam int BLK_COLS = H_ACTIVE >> BLK_LOG2;
    localparam int BLK_ROWS = V_ACTIVE >> BLK_LOG2;
    localparam int N_BLOCKS = BLK_COLS * BLK_ROWS;
    localparam int HSUM_W   = 4 + BLK_LOG2;
    localparam int SUM_W    = 4 + 2 * BLK_LOG2;
    localparam int ADDR_W   = 13;

    typedef enum logic {
        ST_DISARMED = 1'b0,
        ST_ARMED    = 1'b1
    } arm_state_t;

    // Address width for a table of n entries, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bw_block_downscale_col_acc_ram.sv
// Per-block-column partial-sum store: asynchronous read, synchronous write,
// so the top level can read-modify-write one entry in a single cycle.
module bw_block_downscale_col_acc_ram #(
    parameter int DEPTH  = 80,
    parameter int DATA_W = 10,
    parameter int ADDR_W = 7
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Write port; contents need no reset because row 0 of every block overwrites.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/bw_block_downscale.sv
// Averages each BLK x BLK block of the 4-bit pixel stream into one output pixel,
// emitted as a (address, data, valid) write stream for the frame RAM.
//
// state       | meaning
// ST_DISARMED | after reset, waiting for pixel (0,0); all pixels ignored
// ST_ARMED    | processing pixels until the next reset
module bw_block_downscale #(
    parameter int H_ACTIVE = bw_block_downscale_pkg::H_ACTIVE,
    parameter int V_ACTIVE = bw_block_downscale_pkg::V_ACTIVE,
    parameter int BLK_LOG2 = bw_block_downscale_pkg::BLK_LOG2
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic [3:0]  bw_in,
    input  logic        pix_valid,
    input  logic [10:0] hcount_in,
    input  logic [10:0] vcount_in,
    output logic        out_valid,
    output logic [12:0] out_addr,
    output logic [3:0]  out_data,
    output logic        frame_done
);

    import bw_block_downscale_pkg::*;

    localparam int LP_COLS   = H_ACTIVE >> BLK_LOG2;
    localparam int LP_ROWS   = V_ACTIVE >> BLK_LOG2;
    localparam int LP_HSUM_W = 4 + BLK_LOG2;
    localparam int LP_SUM_W  = 4 + 2 * BLK_LOG2;
    localparam int LP_COL_W  = clog2_min1(LP_COLS);
    localparam int LP_ROW_W  = clog2_min1(LP_ROWS);

    localparam logic [10:0]          LP_H_LIM    = 11'(H_ACTIVE);
    localparam logic [10:0]          LP_V_LIM    = 11'(V_ACTIVE);
    localparam logic [BLK_LOG2-1:0]  LP_PH_FIRST = '0;
    localparam logic [BLK_LOG2-1:0]  LP_PH_LAST  = '1;
    localparam logic [LP_COL_W-1:0]  LP_COL_LAST = LP_COL_W'(LP_COLS - 1);
    localparam logic [LP_ROW_W-1:0]  LP_ROW_LAST = LP_ROW_W'(LP_ROWS - 1);

    arm_state_t            r_state;
    logic [LP_HSUM_W-1:0]  r_hacc;
    logic                  r_s1_valid;
    logic [LP_HSUM_W-1:0]  r_s1_hsum;
    logic [LP_COL_W-1:0]   r_s1_col;
    logic [BLK_LOG2-1:0]   r_s1_vph;
    logic [12:0]           r_s1_addr;
    logic                  r_s1_last;
    logic [12:0]           r_addr;
    logic [LP_COL_W-1:0]   r_blk_col;
    logic [LP_ROW_W-1:0]   r_blk_row;

    logic                  w_in_area;
    logic                  w_sof;
    logic                  w_proc;
    logic [BLK_LOG2-1:0]   w_hph;
    logic [BLK_LOG2-1:0]   w_vph;
    logic                  w_blk_end;
    logic                  w_emit_pix;
    logic                  w_last_blk;
    logic [LP_COL_W-1:0]   w_bcol;
    logic [LP_HSUM_W-1:0]  w_hsum_next;
    logic [LP_SUM_W-1:0]   w_rd;
    logic [LP_SUM_W-1:0]   w_total;
    logic [LP_SUM_W-1:0]   w_wr_data;
    logic                  w_we;
    logic                  w_s1_emit;

    assign w_in_area   = pix_valid && (hcount_in < LP_H_LIM) && (vcount_in < LP_V_LIM);
    assign w_sof       = w_in_area && (hcount_in == 11'd0) && (vcount_in == 11'd0);
    assign w_proc      = w_in_area && ((r_state == ST_ARMED) || w_sof);
    assign w_hph       = hcount_in[BLK_LOG2-1:0];
    assign w_vph       = vcount_in[BLK_LOG2-1:0];
    assign w_blk_end   = (w_hph == LP_PH_LAST);
    assign w_emit_pix  = w_blk_end && (w_vph == LP_PH_LAST);
    assign w_last_blk  = (r_blk_col == LP_COL_LAST) && (r_blk_row == LP_ROW_LAST);
    assign w_bcol      = LP_COL_W'(hcount_in >> BLK_LOG2);
    assign w_hsum_next = (w_hph == LP_PH_FIRST) ? LP_HSUM_W'(bw_in)
                                                : r_hacc + LP_HSUM_W'(bw_in);

    // Arming FSM: leave DISARMED only on an accepted (0,0) pixel.
    always_ff @(posedge pclk) begin
        if (rst) begin
            r_state <= ST_DISARMED;
        end else if (w_sof) begin
            r_state <= ST_ARMED;
        end
    end

    // Stage 1: horizontal accumulation, hand off the row sum at the block's last column.
    always_ff @(posedge pclk) begin
        if (rst) begin
            r_hacc     <= '0;
            r_s1_valid <= 1'b0;
            r_s1_hsum  <= '0;
            r_s1_col   <= '0;
            r_s1_vph   <= '0;
            r_s1_addr  <= '0;
            r_s1_last  <= 1'b0;
        end else begin
            r_s1_valid <= w_proc && w_blk_end;
            if (w_proc) begin
                r_hacc <= w_hsum_next;
                if (w_blk_end) begin
                    r_s1_hsum <= w_hsum_next;
                    r_s1_col  <= w_bcol;
                    r_s1_vph  <= w_vph;
                    r_s1_addr <= r_addr;
                    r_s1_last <= w_last_blk;
                end
            end
        end
    end

    // Output address counters; advanced at stage 1 so a following frame start cannot
    // disturb the address of a block still in flight.
    always_ff @(posedge pclk) begin
        if (rst) begin
            r_addr    <= '0;
            r_blk_col <= '0;
            r_blk_row <= '0;
        end else if (w_proc && w_sof) begin
            r_addr    <= '0;
            r_blk_col <= '0;
            r_blk_row <= '0;
        end else if (w_proc && w_emit_pix) begin
            if (w_last_blk) begin
                r_addr    <= '0;
                r_blk_col <= '0;
                r_blk_row <= '0;
            end else begin
                r_addr <= r_addr + 13'd1;
                if (r_blk_col == LP_COL_LAST) begin
                    r_blk_col <= '0;
                    r_blk_row <= r_blk_row + 1'b1;
                end else begin
                    r_blk_col <= r_blk_col + 1'b1;
                end
            end
        end
    end

    assign w_total   = w_rd + LP_SUM_W'(r_s1_hsum);
    assign w_wr_data = (r_s1_vph == LP_PH_FIRST) ? LP_SUM_W'(r_s1_hsum) : w_total;
    assign w_we      = r_s1_valid && !rst && (r_s1_vph != LP_PH_LAST);
    assign w_s1_emit = r_s1_valid && (r_s1_vph == LP_PH_LAST);

    bw_block_downscale_col_acc_ram #(
        .DEPTH  (LP_COLS),
        .DATA_W (LP_SUM_W),
        .ADDR_W (LP_COL_W)
    ) u_col_acc_ram (
        .i_clk   (pclk),
        .i_we    (w_we),
        .i_waddr (r_s1_col),
        .i_wdata (w_wr_data),
        .i_raddr (r_s1_col),
        .o_rdata (w_rd)
    );

    // Stage 2: on the block's last row, emit the truncated average with its address.
    always_ff @(posedge pclk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_addr   <= '0;
            frame_done <= 1'b0;
        end else begin
            out_valid  <= w_s1_emit;
            frame_done <= w_s1_emit && r_s1_last;
            if (w_s1_emit) begin
                out_data <= 4'(w_total >> (2 * BLK_LOG2));
                out_addr <= r_s1_addr;
            end
        end
    end

endmodule

// File: tb/tb_bw_block_downscale.sv
// Directed bench for bw_block_downscale on a reduced 64x32 frame (8x4 blocks of 8x8).
module tb_bw_block_downscale;

    localparam int H  = 64;
    localparam int V  = 32;
    localparam int BL = 3;
    localparam int NB = 32;

    logic        pclk      = 1'b0;
    logic        rst       = 1'b1;
    logic [3:0]  bw_in     = 4'h0;
    logic        pix_valid = 1'b0;
    logic [10:0] hcount_in = 11'd0;
    logic [10:0] vcount_in = 11'd0;
    logic        out_valid;
    logic [12:0] out_addr;
    logic [3:0]  out_data;
    logic        frame_done;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int stray_fd = 0;
    int q_addr[$];
    int q_data[$];
    int q_fd[$];
    int q_cyc[$];
    int last_cyc[$];

    bw_block_downscale #(
        .H_ACTIVE (H),
        .V_ACTIVE (V),
        .BLK_LOG2 (BL)
    ) dut (
        .pclk       (pclk),
        .rst        (rst),
        .bw_in      (bw_in),
        .pix_valid  (pix_valid),
        .hcount_in  (hcount_in),
        .vcount_in  (vcount_in),
        .out_valid  (out_valid),
        .out_addr   (out_addr),
        .out_data   (out_data),
        .frame_done (frame_done)
    );

    always #5 pclk = ~pclk;

    always @(posedge pclk) cyc <= cyc + 1;

    always @(negedge pclk) begin
        if (out_valid === 1'b1) begin
            q_addr.push_back(int'(out_addr));
            q_data.push_back(int'(out_data));
            q_fd.push_back((frame_done === 1'b1) ? 1 : 0);
            q_cyc.push_back(cyc);
        end else if (frame_done !== 1'b0) begin
            stray_fd++;
        end
    end

    function automatic logic [3:0] pix_val(input int mode, input int h, input int v);
        case (mode)
            0:       return 4'hA;
            1:       return 4'(h & 15);
            2:       return 4'hF;
            default: return (((h + v) & 1) != 0) ? 4'hF : 4'h0;
        endcase
    endfunction

    task automatic put(input logic [10:0] h, input logic [10:0] v,
                       input logic [3:0] d, input logic vld);
        hcount_in = h;
        vcount_in = v;
        bw_in     = d;
        pix_valid = vld;
        if (vld && h == 11'(H - 1) && v == 11'(V - 1)) last_cyc.push_back(cyc);
        @(posedge pclk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) put(11'd0, 11'd0, 4'h0, 1'b0);
    endtask

    task automatic clear_q();
        q_addr.delete();
        q_data.delete();
        q_fd.delete();
        q_cyc.delete();
    endtask

    task automatic send_rows(input int mode, input int v0, input int v1,
                             input int gaps, input int extras);
        for (int v = v0; v <= v1; v++) begin
            for (int h = 0; h < H + ((extras != 0) ? 16 : 0); h++) begin
                if (gaps != 0 && $urandom_range(0, 3) == 0) begin
                    repeat ($urandom_range(1, 3))
                        put(11'($urandom), 11'($urandom), 4'($urandom), 1'b0);
                end
                put(11'(h), 11'(v), (h < H) ? pix_val(mode, h, v) : 4'($urandom), 1'b1);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) put(11'd0, 11'd0, 4'hF, 1'b1);
        rst = 1'b0;
        idle(2);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_checks++; if (out_data !== 4'h0) begin n_fail++; $display("FAIL reset_out_data got %h want 0", out_data); end
        n_checks++; if (out_addr !== 13'd0) begin n_fail++; $display("FAIL reset_out_addr got %0d want 0", out_addr); end
        n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done got %b want 0", frame_done); end
        clear_q();
        send_rows(0, 8, 15, 0, 0);
        idle(4);
        n_checks++; if (q_addr.size() != 0) begin n_fail++; $display("FAIL disarmed_outputs got %0d want 0", q_addr.size()); end
    endtask

    task automatic test_const();
        clear_q();
        send_rows(0, 0, V - 1, 0, 0);
        idle(4);
        n_checks++; if (q_addr.size() != NB) begin n_fail++; $display("FAIL const_count got %0d want %0d", q_addr.size(), NB); end
        for (int i = 0; i < q_addr.size(); i++) begin
            n_checks++; if (q_addr[i] != i) begin n_fail++; $display("FAIL const_addr[%0d] got %0d want %0d", i, q_addr[i], i); end
            n_checks++; if (q_data[i] != 10) begin n_fail++; $display("FAIL const_data[%0d] got %0d want 10", i, q_data[i]); end
            n_checks++; if (q_fd[i] != ((i == NB - 1) ? 1 : 0)) begin n_fail++; $display("FAIL const_frame_done[%0d] got %0d", i, q_fd[i]); end
            if (i > 0) begin
                n_checks++; if (q_cyc[i] - q_cyc[i-1] < 8) begin n_fail++; $display("FAIL const_spacing[%0d] got %0d want >=8", i, q_cyc[i] - q_cyc[i-1]); end
            end
        end
        n_checks++; if (stray_fd != 0) begin n_fail++; $display("FAIL stray_frame_done got %0d want 0", stray_fd); end
    endtask

    task automatic test_ramp(input int gaps, input int extras);
        clear_q();
        send_rows(1, 0, V - 1, gaps, extras);
        idle(4);
        n_checks++; if (q_addr.size() != NB) begin n_fail++; $display("FAIL ramp_count(g=%0d) got %0d want %0d", gaps, q_addr.size(), NB); end
        for (int i = 0; i < q_addr.size(); i++) begin
            n_checks++; if (q_addr[i] != i) begin n_fail++; $display("FAIL ramp_addr[%0d] got %0d want %0d", i, q_addr[i], i); end
            n_checks++; if (q_data[i] != (((i % 2) == 0) ? 3 : 11)) begin n_fail++; $display("FAIL ramp_data[%0d] got %0d want %0d", i, q_data[i], ((i % 2) == 0) ? 3 : 11); end
            n_checks++; if (q_fd[i] != ((i == NB - 1) ? 1 : 0)) begin n_fail++; $display("FAIL ramp_frame_done[%0d] got %0d", i, q_fd[i]); end
        end
    endtask

    task automatic test_white_checker();
        clear_q();
        send_rows(2, 0, V - 1, 0, 0);
        idle(4);
        n_checks++; if (q_data.size() != NB) begin n_fail++; $display("FAIL white_count got %0d want %0d", q_data.size(), NB); end
        for (int i = 0; i < q_data.size(); i++) begin
            n_checks++; if (q_data[i] != 15) begin n_fail++; $display("FAIL white_data[%0d] got %0d want 15", i, q_data[i]); end
        end
        clear_q();
        send_rows(3, 0, V - 1, 0, 0);
        idle(4);
        n_checks++; if (q_data.size() != NB) begin n_fail++; $display("FAIL checker_count got %0d want %0d", q_data.size(), NB); end
        for (int i = 0; i < q_data.size(); i++) begin
            n_checks++; if (q_data[i] != 7) begin n_fail++; $display("FAIL checker_data[%0d] got %0d want 7", i, q_data[i]); end
            n_checks++; if (q_addr[i] != i) begin n_fail++; $display("FAIL checker_addr[%0d] got %0d want %0d", i, q_addr[i], i); end
        end
    endtask

    task automatic test_reset_midframe();
        int rst_cyc;
        clear_q();
        send_rows(1, 0, 15, 0, 0);
        rst = 1'b1;
        rst_cyc = cyc;
        put(11'd0, 11'd16, 4'h0, 1'b1);
        rst = 1'b0;
        send_rows(1, 16, V - 1, 0, 0);
        idle(4);
        n_checks++; if (q_addr.size() != 15) begin n_fail++; $display("FAIL midrst_count got %0d want 15", q_addr.size()); end
        if (q_addr.size() > 0) begin
            n_checks++; if (q_cyc[q_cyc.size()-1] >= rst_cyc) begin n_fail++; $display("FAIL midrst_late_output cycle %0d rst at %0d", q_cyc[q_cyc.size()-1], rst_cyc); end
            n_checks++; if (q_addr[q_addr.size()-1] != q_addr.size() - 1) begin n_fail++; $display("FAIL midrst_last_addr got %0d want %0d", q_addr[q_addr.size()-1], q_addr.size() - 1); end
        end
        clear_q();
        send_rows(3, 0, V - 1, 0, 0);
        idle(4);
        n_checks++; if (q_addr.size() != NB) begin n_fail++; $display("FAIL postrst_count got %0d want %0d", q_addr.size(), NB); end
        for (int i = 0; i < q_addr.size(); i++) begin
            n_checks++; if (q_addr[i] != i) begin n_fail++; $display("FAIL postrst_addr[%0d] got %0d want %0d", i, q_addr[i], i); end
            n_checks++; if (q_data[i] != 7) begin n_fail++; $display("FAIL postrst_data[%0d] got %0d want 7", i, q_data[i]); end
        end
    endtask

    task automatic test_back_to_back();
        int n_fd;
        clear_q();
        last_cyc.delete();
        send_rows(2, 0, V - 1, 0, 0);
        send_rows(0, 0, V - 1, 0, 0);
        idle(4);
        n_fd = 0;
        foreach (q_fd[i]) n_fd += q_fd[i];
        n_checks++; if (q_addr.size() != 2 * NB) begin n_fail++; $display("FAIL b2b_count got %0d want %0d", q_addr.size(), 2 * NB); end
        n_checks++; if (n_fd != 2) begin n_fail++; $display("FAIL b2b_frame_done_count got %0d want 2", n_fd); end
        if (q_addr.size() == 2 * NB && last_cyc.size() == 2) begin
            n_checks++; if (q_addr[NB-1] != NB - 1) begin n_fail++; $display("FAIL b2b_addr_last got %0d want %0d", q_addr[NB-1], NB - 1); end
            n_checks++; if (q_addr[NB] != 0) begin n_fail++; $display("FAIL b2b_addr_wrap got %0d want 0", q_addr[NB]); end
            n_checks++; if (q_addr[2*NB-1] != NB - 1) begin n_fail++; $display("FAIL b2b_addr_end got %0d want %0d", q_addr[2*NB-1], NB - 1); end
            n_checks++; if (q_fd[NB-1] != 1 || q_fd[2*NB-1] != 1) begin n_fail++; $display("FAIL b2b_frame_done_pos got %0d/%0d want 1/1", q_fd[NB-1], q_fd[2*NB-1]); end
            n_checks++; if (q_cyc[NB-1] != last_cyc[0] + 2) begin n_fail++; $display("FAIL b2b_latency1 got %0d want %0d", q_cyc[NB-1] - last_cyc[0], 2); end
            n_checks++; if (q_cyc[2*NB-1] != last_cyc[1] + 2) begin n_fail++; $display("FAIL b2b_latency2 got %0d want %0d", q_cyc[2*NB-1] - last_cyc[1], 2); end
            n_checks++; if (q_data[NB-1] != 15) begin n_fail++; $display("FAIL b2b_data1 got %0d want 15", q_data[NB-1]); end
            n_checks++; if (q_data[NB] != 10) begin n_fail++; $display("FAIL b2b_data2 got %0d want 10", q_data[NB]); end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_const();
        test_ramp(0, 0);
        test_white_checker();
        test_ramp(1, 1);
        test_reset_midframe();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
